pixel_downscaler_3x: RTL

- Streaming 3:1 box-filter decimator for 24-bit RGB; the inverse direction of the 3x bicubic upscaler.
- Consumes a raster of IMG_W x IMG_H pixels and emits (IMG_W/3) x (IMG_H/3) pixels. Each output pixel is the rounded mean of one non-overlapping 3x3 block, computed per channel.
- Sits after the upscaler in round-trip regression and on the capture path.
- No backpressure; same valid-only stream protocol as the upscaler.

---
 rtl/upscaler_pkg.sv | 24 ++
 rtl/ds_row_accum_ram.sv | 29 ++
 rtl/pixel_downscaler_3x.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/upscaler_pkg.sv
// Shared definitions for the upscaler / downscaler pixel pipelines:
// RGB field positions, the 1/9 reciprocal used by the 3:1 box filter,
// and the packed RGB type.
package upscaler_pkg;

    localparam int R_MSB = 23;
    localparam int R_LSB = 16;
    localparam int G_MSB = 15;
    localparam int G_LSB = 8;
    localparam int B_MSB = 7;
    localparam int B_LSB = 0;

    // tsum * DS_RECIP9 + DS_ROUND, then >> 16, gives round(tsum / 9)
    // for every tsum in 0..2295 (nine 8-bit samples).
    localparam logic [15:0] DS_RECIP9 = 16'd7282;
    localparam logic [25:0] DS_ROUND  = 26'd32768;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

endpackage

// File: rtl/ds_row_accum_ram.sv
// Row accumulator storage for the 3:1 downscaler: one word per output
// column holding the partial vertical sums of all three channels.
// Simple dual port, asynchronous read, synchronous write (distributed RAM).
module ds_row_accum_ram #(
    parameter int DEPTH = 128,
    parameter int WIDTH = 36,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Synchronous write port; contents are never cleared, the first
    // line of every block row overwrites them.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pixel_downscaler_3x.sv
// Streaming 3:1 box-filter decimator for 24-bit RGB. Every non-overlapping
// 3x3 block of the input raster becomes one output pixel holding the
// rounded per-channel mean. Valid-only stream, no backpressure.
// Optional: define DS_EOL_FLAG_EN to add the eol_out port, flagging the
// last output pixel of every output line.
module pixel_downscaler_3x #(
    parameter int IMG_W = 384,
    parameter int IMG_H = 216
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] pixel_in,
    input  logic        input_valid,
    output logic [23:0] pixel_out,
    output logic        output_valid,
    output logic        frame_done
`ifdef DS_EOL_FLAG_EN
    ,
    output logic        eol_out
`endif
);

    import upscaler_pkg::*;

    localparam int NB = IMG_W / 3;
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;

    generate
        if (IMG_W % 3 != 0) begin : g_bad_width
            $error("pixel_downscaler_3x: IMG_W must be a multiple of 3");
        end
        if (IMG_H % 3 != 0) begin : g_bad_height
            $error("pixel_downscaler_3x: IMG_H must be a multiple of 3");
        end
    endgenerate

    // Rounded divide by nine through a reciprocal multiply; the largest
    // possible sum (2295) rounds to 255, so no saturation is required.
    function automatic logic [7:0] div9(input logic [11:0] t);
        logic [25:0] prod;
        prod = 26'(t) * 26'(DS_RECIP9) + DS_ROUND;
        return 8'(prod >> 16);
    endfunction

    // Raster position
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [1:0]    hphase;
    logic [1:0]    vphase;
    logic [BW-1:0] blk;

    // Channel index 2 = R, 1 = G, 0 = B
    logic [2:0][7:0]  px;
    logic [2:0][9:0]  hacc;
    logic [2:0][9:0]  hsum;
    logic [2:0][11:0] tsum;
    logic [2:0][11:0] mem_rd;

    logic blk_end;
    logic ram_we;

    // Pipeline
    logic [2:0][11:0] tsum_p1;
    logic             vld_p1;
    logic             last_p1;
    rgb_t             quo_p2;
    logic             vld_p2;
    logic             last_p2;
`ifdef DS_EOL_FLAG_EN
    logic             eol_p1;
    logic             eol_p2;
`endif

    assign px[2] = pixel_in[R_MSB:R_LSB];
    assign px[1] = pixel_in[G_MSB:G_LSB];
    assign px[0] = pixel_in[B_MSB:B_LSB];

    assign blk_end = input_valid && (hphase == 2'd2);
    assign ram_we  = blk_end && (vphase != 2'd2);

    ds_row_accum_ram #(
        .DEPTH (NB),
        .WIDTH (36)
    ) u_row_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (blk),
        .wdata (tsum),
        .raddr (blk),
        .rdata (mem_rd)
    );

    // Horizontal 3-tap sum plus the vertical partial from the row memory;
    // the first line of a block row ignores stale memory contents.
    always_comb begin
        hsum = '0;
        tsum = '0;
        for (int i = 0; i < 3; i++) begin
            hsum[i] = hacc[i] + 10'(px[i]);
            tsum[i] = 12'(hsum[i]) + ((vphase == 2'd0) ? 12'd0 : mem_rd[i]);
        end
    end

    // Raster counters, advanced only on accepted pixels; the next frame
    // follows immediately after the last pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            col    <= '0;
            row    <= '0;
            hphase <= 2'd0;
            vphase <= 2'd0;
            blk    <= '0;
        end else if (input_valid) begin
            if (col == CW'(IMG_W - 1)) begin
                col    <= '0;
                hphase <= 2'd0;
                blk    <= '0;
                if (row == RW'(IMG_H - 1)) begin
                    row    <= '0;
                    vphase <= 2'd0;
                end else begin
                    row    <= row + 1'b1;
                    vphase <= (vphase == 2'd2) ? 2'd0 : vphase + 2'd1;
                end
            end else begin
                col <= col + 1'b1;
                if (hphase == 2'd2) begin
                    hphase <= 2'd0;
                    blk    <= blk + 1'b1;
                end else begin
                    hphase <= hphase + 2'd1;
                end
            end
        end
    end

    // Horizontal accumulator: load on the first pixel of a block, add on
    // the second; the third is summed combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            hacc <= '0;
        end else if (input_valid) begin
            for (int i = 0; i < 3; i++) begin
                if (hphase == 2'd0) begin
                    hacc[i] <= 10'(px[i]);
                end else if (hphase == 2'd1) begin
                    hacc[i] <= hacc[i] + 10'(px[i]);
                end
            end
        end
    end

    // ---- stage 1: block sum captured on the block's final pixel ----
    // Control flags for stage 1
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end else begin
            vld_p1  <= blk_end && (vphase == 2'd2);
            last_p1 <= blk_end && (vphase == 2'd2) && (blk == BW'(NB - 1))
                       && (row == RW'(IMG_H - 1));
        end
    end

    // Stage 1 data register
    always_ff @(posedge clk) begin
        if (blk_end) begin
            tsum_p1 <= tsum;
        end
    end

    // ---- stage 2: reciprocal divide ----
    // Control flags for stage 2
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2  <= 1'b0;
            last_p2 <= 1'b0;
        end else begin
            vld_p2  <= vld_p1;
            last_p2 <= last_p1;
        end
    end

    // Stage 2 data register
    always_ff @(posedge clk) begin
        if (vld_p1) begin
            quo_p2.r <= div9(tsum_p1[2]);
            quo_p2.g <= div9(tsum_p1[1]);
            quo_p2.b <= div9(tsum_p1[0]);
        end
    end

    // ---- output register ----
    // Output pixel and strobes; pixel_out holds between outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_out    <= 24'h0;
            output_valid <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            output_valid <= vld_p2;
            frame_done   <= last_p2;
            if (vld_p2) begin
                pixel_out <= quo_p2;
            end
        end
    end

`ifdef DS_EOL_FLAG_EN
    // End-of-output-line flag travelling with the block result
    always_ff @(posedge clk) begin
        if (rst) begin
            eol_p1  <= 1'b0;
            eol_p2  <= 1'b0;
            eol_out <= 1'b0;
        end else begin
            eol_p1  <= blk_end && (vphase == 2'd2) && (blk == BW'(NB - 1));
            eol_p2  <= eol_p1;
            eol_out <= eol_p2;
        end
    end
`endif

endmodule
